btn_pulse_gen: RTL and testbench

//   Upstream stage for the 2-bit press counter: converts a raw, bouncing push-button

---
 rtl/btn_pulse_gen.sv | 105 ++++++++++
 tb/tb_btn_pulse_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_pulse_gen.sv
// Push-button conditioner: 2-flop synchroniser, press/release debounce, one-cycle x per press.
// x and btn_level are registered; a press held from edge 1 yields x after edge DEBOUNCE_CYCLES+3.
module btn_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic x,
  output logic btn_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             level_q, level_d;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = 1'b0;
    level_d = level_q;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        // Any low sample during the press window means bounce; drop back silently.
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          x_d     = 1'b1;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // Returning high here is release bounce: back to HELD without a new pulse.
        if (sync2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      level_q <= level_d;
    end
  end

  assign x         = x_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Self-checking bench for btn_pulse_gen (DEBOUNCE_CYCLES=4): directed scenarios plus random bouncing input.
module tb_btn_pulse_gen;

  localparam int N = 4;

  logic clk;
  logic reset;
  logic btn_in;
  logic x;
  logic btn_level;

  int checks;
  int failures;

  btn_pulse_gen #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .x(x),
    .btn_level(btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the input is seen two edges late; the debounced level flips once the
  // seen value has disagreed with it on N+1 consecutive edges, and a rise emits x.
  logic [1:0] m_hist;
  logic       m_seen;
  logic       m_lvl;
  logic       m_x;
  int         m_run;

  always @(posedge clk) begin
    if (!reset) begin
      m_hist = 2'b00;
      m_lvl  = 1'b0;
      m_x    = 1'b0;
      m_run  = 0;
    end else begin
      m_seen = m_hist[1];
      m_x    = 1'b0;
      if (m_seen != m_lvl) begin
        m_run = m_run + 1;
        if (m_run == N + 1) begin
          m_lvl = m_seen;
          m_x   = m_seen;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_hist = {m_hist[0], btn_in};
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle_low();
    btn_in = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    btn_in = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (x !== 1'b0 || btn_level !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d x=%b lvl=%b required x=0 lvl=0", c, x, btn_level);
      end
    end
    reset = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      checks++;
      if (x !== (c == 7) || btn_level !== (c >= 7)) begin
        failures++;
        $display("FAIL reset_first_press edge=%0d x=%b lvl=%b required x=%b lvl=%b",
                 c, x, btn_level, (c == 7), (c >= 7));
      end
    end
  endtask

  task automatic test_clean_press();
    int pulses;
    settle_low();
    pulses = 0;
    btn_in = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (x === 1'b1) pulses++;
      checks++;
      if (x !== (c == 7) || btn_level !== (c >= 7)) begin
        failures++;
        $display("FAIL clean_press edge=%0d x=%b lvl=%b required x=%b lvl=%b",
                 c, x, btn_level, (c == 7), (c >= 7));
      end
    end
    btn_in = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (x === 1'b1) pulses++;
      checks++;
      if (x !== 1'b0 || btn_level !== (c < 7)) begin
        failures++;
        $display("FAIL clean_release edge=%0d x=%b lvl=%b required x=0 lvl=%b",
                 c, x, btn_level, (c < 7));
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL clean_pulse_count got=%0d required=1", pulses);
    end
  endtask

  task automatic test_press_bounce();
    logic [4:0] pat;
    int pulses;
    int first;
    settle_low();
    pat    = 5'b10101;
    pulses = 0;
    first  = 0;
    for (int c = 1; c <= 25; c++) begin
      btn_in = (c <= 5) ? pat[c-1] : 1'b1;
      tick();
      if (x === 1'b1) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    checks++;
    if (pulses != 1 || first != 11) begin
      failures++;
      $display("FAIL press_bounce pulses=%0d first_edge=%0d required pulses=1 first_edge=11", pulses, first);
    end
  endtask

  task automatic test_release_bounce();
    logic [3:0] pat;
    int pulses;
    settle_low();
    btn_in = 1'b1;
    repeat (20) tick();
    checks++;
    if (btn_level !== 1'b1) begin
      failures++;
      $display("FAIL release_bounce_held lvl=%b required=1", btn_level);
    end
    pat    = 4'b1010;
    pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      btn_in = (c <= 4) ? pat[c-1] : 1'b0;
      tick();
      if (x === 1'b1) pulses++;
      checks++;
      if (btn_level !== (c < 11)) begin
        failures++;
        $display("FAIL release_bounce_level edge=%0d lvl=%b required=%b", c, btn_level, (c < 11));
      end
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL release_bounce_pulses got=%0d required=0", pulses);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int pulses;
    settle_low();
    btn_in = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++;
      if (x !== 1'b0 || btn_level !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid cyc=%0d x=%b lvl=%b required x=0 lvl=0", c, x, btn_level);
      end
    end
    reset  = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (x === 1'b1) pulses++;
      checks++;
      if (x !== (c == 7)) begin
        failures++;
        $display("FAIL reset_mid_repress edge=%0d x=%b required=%b", c, x, (c == 7));
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL reset_mid_pulse_count got=%0d required=1", pulses);
    end
  endtask

  task automatic test_counter_chain();
    logic [1:0] q;
    logic       z;
    logic [1:0] exp_q [4];
    exp_q = '{2'b01, 2'b10, 2'b11, 2'b00};
    settle_low();
    q = 2'b00;
    for (int p = 0; p < 4; p++) begin
      z = 1'b0;
      btn_in = 1'b1;
      for (int c = 0; c < 12; c++) begin
        tick();
        if (x === 1'b1) begin
          z = (q == 2'b11);
          q = q + 2'd1;
        end
      end
      btn_in = 1'b0;
      repeat (12) tick();
      checks++;
      if (q !== exp_q[p] || z !== (p == 3)) begin
        failures++;
        $display("FAIL chain press=%0d q=%b z=%b required q=%b z=%b", p + 1, q, z, exp_q[p], (p == 3));
      end
    end
  endtask

  task automatic test_random();
    int hold;
    settle_low();
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        btn_in = ~btn_in;
        hold   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 14)) : int'($urandom_range(1, 6));
      end
      hold--;
      reset = ($urandom_range(0, 59) != 0);
      tick();
      checks++;
      if (x !== m_x || btn_level !== m_lvl) begin
        failures++;
        $display("FAIL random cyc=%0d x=%b lvl=%b required x=%b lvl=%b", c, x, btn_level, m_x, m_lvl);
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    btn_in   = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_reset_mid_debounce();
    test_counter_chain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
